// File: rtl/matmul_pkg.sv
// Shared types and helpers for the matmul output collector.
// Width helpers keep the top and the column accumulators in agreement.
package matmul_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        DONE
    } wb_state_t;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_width(input int rows);
        return $clog2(rows + 1);
    endfunction

    function automatic int acc_width(input int word, input int rows);
        return word + $clog2(rows) + 1;
    endfunction

    // Clamp to the signed w-bit range when en; caller truncates to w bits.
    function automatic logic signed [63:0] sat_word(
        input logic signed [63:0] v,
        input int unsigned        w,
        input bit                 en
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (en && v > hi) return hi;
        if (en && v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/matmul_output_collector_col_accumulator.sv
// One output column: capture toggle, row counter, per-row accumulators
// and a sticky overrun flag.
module col_accumulator
    import matmul_pkg::*;
#(
    parameter int ROWS      = 4,
    parameter int WORD_SIZE = 16,
    parameter int AW        = 19,
    parameter int RW        = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cap_en_i,
    input  logic                 valid_i,
    input  logic [WORD_SIZE-1:0] data_i,
    input  logic                 clr_cnt_i,
    input  logic                 clr_acc_i,
    input  logic [RW-1:0]        rd_row_i,
    output logic signed [AW-1:0] rd_data_o,
    output logic                 overrun_o
);

    localparam int CW = cnt_width(ROWS);

    logic                 tog_q;
    logic [CW-1:0]        cnt_q;
    logic signed [AW-1:0] acc_q [ROWS];
    logic                 ovr_q;

    logic                 sample;
    logic                 full;
    logic signed [AW-1:0] ext;

    // Each value is held two cycles upstream; take only the first.
    assign sample = valid_i && cap_en_i && !tog_q;
    assign full   = (cnt_q == CW'(ROWS));
    assign ext    = AW'($signed(data_i));

    always_ff @(posedge clk) begin
        if (rst) begin
            tog_q <= 1'b0;
            cnt_q <= '0;
            ovr_q <= 1'b0;
            for (int r = 0; r < ROWS; r++) begin
                acc_q[r] <= '0;
            end
        end else begin
            if (clr_cnt_i) begin
                tog_q <= 1'b0;
                cnt_q <= '0;
            end else begin
                if (!valid_i) begin
                    tog_q <= 1'b0;
                end else if (cap_en_i) begin
                    tog_q <= !tog_q;
                end
                if (sample && !full) begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end
            if (sample && full) begin
                ovr_q <= 1'b1;
            end
            for (int r = 0; r < ROWS; r++) begin
                if (clr_acc_i) begin
                    acc_q[r] <= '0;
                end else if (sample && !full && cnt_q == CW'(r)) begin
                    acc_q[r] <= acc_q[r] + ext;
                end
            end
        end
    end

    always_comb begin
        rd_data_o = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (rd_row_i == RW'(r)) begin
                rd_data_o = acc_q[r];
            end
        end
    end

    assign overrun_o = ovr_q;

endmodule

// File: rtl/matmul_output_collector.sv
// Collects SA and proxy column outputs, sums them per element and
// writes the finished tile to memory in port-width chunks.
module matmul_output_collector
    import matmul_pkg::*;
#(
    parameter int          ROWS           = 4,
    parameter int          COLS           = 4,
    parameter int          WORD_SIZE      = 16,
    parameter int          MEM_PORT_WIDTH = 64,
    parameter int unsigned BASE_ADDR      = 0,
    parameter int unsigned ADDR_INCR      = 8,
    parameter int          SATURATE       = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stall_i,
    input  logic                      start_i,
    input  logic                      acc_mode_i,
    input  logic [COLS*WORD_SIZE-1:0] sa_data_i,
    input  logic [COLS-1:0]           sa_valid_i,
    input  logic [COLS*WORD_SIZE-1:0] proxy_data_i,
    input  logic [COLS-1:0]           proxy_valid_i,
    output logic [31:0]               mem_addr_o,
    output logic [MEM_PORT_WIDTH-1:0] mem_data_o,
    output logic                      mem_wr_en_o,
    input  logic                      mem_wr_ack_i,
    output logic                      busy_o,
    output logic                      wr_output_done_o,
    output logic                      overrun_o
);

    localparam int AW     = acc_width(WORD_SIZE, ROWS);
    localparam int RW     = idx_width(ROWS);
    localparam int EPC    = MEM_PORT_WIDTH / WORD_SIZE;
    localparam int CHUNKS = ceil_div(COLS * WORD_SIZE, MEM_PORT_WIDTH);
    localparam int KW     = idx_width(CHUNKS);

    wb_state_t                 state_q;
    logic [RW-1:0]             row_q;
    logic [KW-1:0]             chunk_q;
    logic                      acc_mode_q;
    logic [31:0]               mem_addr_q;
    logic [MEM_PORT_WIDTH-1:0] mem_data_q;
    logic                      mem_wr_en_q;
    logic                      busy_q;
    logic                      done_q;

    logic                      cap_en;
    logic                      clr_cnt;
    logic                      clr_acc;
    logic                      last_row;
    logic                      last_chunk;
    logic [31:0]               addr_d;
    logic [MEM_PORT_WIDTH-1:0] data_d;

    logic signed [AW-1:0]      sa_rd  [COLS];
    logic signed [AW-1:0]      px_rd  [COLS];
    logic signed [AW:0]        sum    [COLS];
    logic [WORD_SIZE-1:0]      elem   [COLS];
    logic [COLS-1:0]           sa_ovr;
    logic [COLS-1:0]           px_ovr;

    assign cap_en  = (state_q == IDLE) && !stall_i;
    assign clr_cnt = (state_q == DONE);
    assign clr_acc = (state_q == DONE) && !acc_mode_q;

    for (genvar c = 0; c < COLS; c++) begin : g_col
        col_accumulator #(
            .ROWS      (ROWS),
            .WORD_SIZE (WORD_SIZE),
            .AW        (AW),
            .RW        (RW)
        ) u_sa (
            .clk       (clk),
            .rst       (rst),
            .cap_en_i  (cap_en),
            .valid_i   (sa_valid_i[c]),
            .data_i    (sa_data_i[c*WORD_SIZE +: WORD_SIZE]),
            .clr_cnt_i (clr_cnt),
            .clr_acc_i (clr_acc),
            .rd_row_i  (row_q),
            .rd_data_o (sa_rd[c]),
            .overrun_o (sa_ovr[c])
        );

        col_accumulator #(
            .ROWS      (ROWS),
            .WORD_SIZE (WORD_SIZE),
            .AW        (AW),
            .RW        (RW)
        ) u_px (
            .clk       (clk),
            .rst       (rst),
            .cap_en_i  (cap_en),
            .valid_i   (proxy_valid_i[c]),
            .data_i    (proxy_data_i[c*WORD_SIZE +: WORD_SIZE]),
            .clr_cnt_i (clr_cnt),
            .clr_acc_i (clr_acc),
            .rd_row_i  (row_q),
            .rd_data_o (px_rd[c]),
            .overrun_o (px_ovr[c])
        );

        // One extra bit so the SA + proxy sum never wraps before clamping.
        assign sum[c] = {sa_rd[c][AW-1], sa_rd[c]}
                      + {px_rd[c][AW-1], px_rd[c]};
        assign elem[c] = WORD_SIZE'(sat_word(64'(sum[c]), WORD_SIZE,
                                             SATURATE != 0));
    end

    assign last_row   = (row_q == RW'(ROWS - 1));
    assign last_chunk = (chunk_q == KW'(CHUNKS - 1));

    assign addr_d = 32'(BASE_ADDR
                  + (32'(row_q) * CHUNKS + 32'(chunk_q)) * ADDR_INCR);

    always_comb begin
        data_d = '0;
        for (int e = 0; e < EPC; e++) begin
            for (int c = 0; c < COLS; c++) begin
                if (int'(chunk_q) * EPC + e == c) begin
                    data_d[e*WORD_SIZE +: WORD_SIZE] = elem[c];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            row_q       <= '0;
            chunk_q     <= '0;
            acc_mode_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            mem_wr_en_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        acc_mode_q <= acc_mode_i;
                        row_q      <= '0;
                        chunk_q    <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_addr_q  <= addr_d;
                    mem_data_q  <= data_d;
                    mem_wr_en_q <= 1'b1;
                    state_q     <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (mem_wr_ack_i) begin
                        mem_wr_en_q <= 1'b0;
                        if (last_row && last_chunk) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            if (last_chunk) begin
                                chunk_q <= '0;
                                row_q   <= row_q + RW'(1);
                            end else begin
                                chunk_q <= chunk_q + KW'(1);
                            end
                            state_q <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_addr_o       = mem_addr_q;
    assign mem_data_o       = mem_data_q;
    assign mem_wr_en_o      = mem_wr_en_q;
    assign busy_o           = busy_q;
    assign wr_output_done_o = done_q;
    assign overrun_o        = |{sa_ovr, px_ovr};

endmodule

// File: tb/tb_matmul_output_collector.sv
// Directed and randomised tiles against a per-element arithmetic model;
// a second instance with SATURATE=0 shares all stimulus.
module tb_matmul_output_collector;

    localparam int          ROWS   = 4;
    localparam int          COLS   = 4;
    localparam int          W      = 16;
    localparam int          MPW    = 48;
    localparam int          EPC    = MPW / W;
    localparam int          CHUNKS = (COLS * W + MPW - 1) / MPW;
    localparam int unsigned BASE   = 32'h100;
    localparam int unsigned INCR   = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              stall_i = 1'b0;
    logic              start_i = 1'b0;
    logic              acc_mode_i = 1'b0;
    logic [COLS*W-1:0] sa_data_i = '0;
    logic [COLS*W-1:0] px_data_i = '0;
    logic [COLS-1:0]   sa_valid_i = '0;
    logic [COLS-1:0]   px_valid_i = '0;
    logic              mem_wr_ack_i = 1'b0;

    logic [31:0]       mem_addr_o;
    logic [MPW-1:0]    mem_data_o;
    logic              mem_wr_en_o;
    logic              busy_o;
    logic              wr_output_done_o;
    logic              overrun_o;

    logic [31:0]       w_addr;
    logic [MPW-1:0]    w_data;
    logic              w_en;
    logic              w_busy;
    logic              w_done;
    logic              w_ovr;

    matmul_output_collector #(
        .ROWS(ROWS), .COLS(COLS), .WORD_SIZE(W),
        .MEM_PORT_WIDTH(MPW), .BASE_ADDR(BASE),
        .ADDR_INCR(INCR), .SATURATE(1)
    ) u_dut (
        .clk(clk), .rst(rst), .stall_i(stall_i),
        .start_i(start_i), .acc_mode_i(acc_mode_i),
        .sa_data_i(sa_data_i), .sa_valid_i(sa_valid_i),
        .proxy_data_i(px_data_i), .proxy_valid_i(px_valid_i),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_wr_en_o(mem_wr_en_o), .mem_wr_ack_i(mem_wr_ack_i),
        .busy_o(busy_o), .wr_output_done_o(wr_output_done_o),
        .overrun_o(overrun_o)
    );

    matmul_output_collector #(
        .ROWS(ROWS), .COLS(COLS), .WORD_SIZE(W),
        .MEM_PORT_WIDTH(MPW), .BASE_ADDR(BASE),
        .ADDR_INCR(INCR), .SATURATE(0)
    ) u_wrap (
        .clk(clk), .rst(rst), .stall_i(stall_i),
        .start_i(start_i), .acc_mode_i(acc_mode_i),
        .sa_data_i(sa_data_i), .sa_valid_i(sa_valid_i),
        .proxy_data_i(px_data_i), .proxy_valid_i(px_valid_i),
        .mem_addr_o(w_addr), .mem_data_o(w_data),
        .mem_wr_en_o(w_en), .mem_wr_ack_i(mem_wr_ack_i),
        .busy_o(w_busy), .wr_output_done_o(w_done),
        .overrun_o(w_ovr)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int sa_m [ROWS][COLS];
    int px_m [ROWS][COLS];
    int sa_cnt [COLS];
    int px_cnt [COLS];
    bit m_ovr;
    int tile_sa [ROWS][COLS];
    int tile_px [ROWS][COLS];

    logic [31:0]    wa [$];
    logic [MPW-1:0] wd [$];
    logic [MPW-1:0] ww [$];

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                sa_m[r][c] = 0;
                px_m[r][c] = 0;
            end
        end
        for (int c = 0; c < COLS; c++) begin
            sa_cnt[c] = 0;
            px_cnt[c] = 0;
        end
        m_ovr = 0;
    endtask

    task automatic model_sample(input bit px, input int c, input int v);
        if (px) begin
            if (px_cnt[c] < ROWS) begin
                px_m[px_cnt[c]][c] += v;
                px_cnt[c]++;
            end else m_ovr = 1;
        end else begin
            if (sa_cnt[c] < ROWS) begin
                sa_m[sa_cnt[c]][c] += v;
                sa_cnt[c]++;
            end else m_ovr = 1;
        end
    endtask

    function automatic int model_elem(input int r, input int c,
                                      input bit sat);
        int s;
        s = sa_m[r][c] + px_m[r][c];
        if (sat && s > 32767) s = 32767;
        if (sat && s < -32768) s = -32768;
        return s;
    endfunction

    function automatic logic [MPW-1:0] model_pack(input int r, input int k,
                                                  input bit sat);
        logic [MPW-1:0] d;
        d = '0;
        for (int e = 0; e < EPC; e++) begin
            if (k * EPC + e < COLS) begin
                d[e*W +: W] = W'(model_elem(r, k * EPC + e, sat));
            end
        end
        return d;
    endfunction

    task automatic feed_tile();
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                sa_data_i[c*W +: W] = W'(tile_sa[r][c]);
                px_data_i[c*W +: W] = W'(tile_px[r][c]);
                model_sample(0, c, tile_sa[r][c]);
                model_sample(1, c, tile_px[r][c]);
            end
            sa_valid_i = '1;
            px_valid_i = '1;
            step();
            step();
        end
        sa_valid_i = '0;
        px_valid_i = '0;
        step();
    endtask

    task automatic rand_tile(input int lo, input int hi);
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                tile_sa[r][c] = lo + int'($urandom_range(0, hi - lo));
                tile_px[r][c] = lo + int'($urandom_range(0, hi - lo));
            end
        end
    endtask

    task automatic run_wb(input bit mode, input int delay, input bit junk);
        int             cyc;
        int             hold;
        int             dones;
        int             first_en;
        bit             unstable;
        logic [31:0]    la;
        logic [MPW-1:0] ld;
        cyc = 0;
        hold = 0;
        dones = 0;
        first_en = -1;
        unstable = 0;
        la = '0;
        ld = '0;
        wa.delete();
        wd.delete();
        ww.delete();
        acc_mode_i = mode;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        check("busy_after_start", busy_o, 1'b1);
        if (junk) begin
            sa_data_i = {$urandom, $urandom};
            px_data_i = {$urandom, $urandom};
            sa_valid_i = '1;
            px_valid_i = '1;
        end
        while (busy_o && cyc < 1000) begin
            mem_wr_ack_i = 1'b0;
            if (wr_output_done_o) dones++;
            if (mem_wr_en_o) begin
                if (first_en < 0) first_en = cyc;
                if (hold == 0) begin
                    la = mem_addr_o;
                    ld = mem_data_o;
                    unstable = 0;
                end else if (mem_addr_o !== la || mem_data_o !== ld) begin
                    unstable = 1;
                end
                if (hold == delay) begin
                    mem_wr_ack_i = 1'b1;
                    wa.push_back(la);
                    wd.push_back(ld);
                    ww.push_back(w_data);
                    if (delay > 0) check("held_while_waiting", unstable, 0);
                    hold = 0;
                end else begin
                    hold++;
                end
            end
            step();
            cyc++;
        end
        if (wr_output_done_o) dones++;
        mem_wr_ack_i = 1'b0;
        sa_valid_i = '0;
        px_valid_i = '0;
        check("wb_terminated", busy_o, 1'b0);
        check("done_pulses", dones, 1);
        check("first_en_latency", first_en, 1);
        check("write_count", wa.size(), ROWS * CHUNKS);
        for (int r = 0; r < ROWS; r++) begin
            for (int k = 0; k < CHUNKS; k++) begin
                if (r * CHUNKS + k < wa.size()) begin
                    check("wr_addr", wa[r*CHUNKS+k],
                          BASE + (r * CHUNKS + k) * INCR);
                    check("wr_data_sat", wd[r*CHUNKS+k], model_pack(r, k, 1));
                    check("wr_data_wrap", ww[r*CHUNKS+k], model_pack(r, k, 0));
                end
            end
        end
        for (int c = 0; c < COLS; c++) begin
            sa_cnt[c] = 0;
            px_cnt[c] = 0;
        end
        if (!mode) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    sa_m[r][c] = 0;
                    px_m[r][c] = 0;
                end
            end
        end
    endtask

    initial begin
        int             cyc;
        logic [MPW-1:0] d;
        model_reset();

        rst = 1'b1;
        repeat (3) step();
        check("rst_wr_en", mem_wr_en_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_done", wr_output_done_o, 1'b0);
        check("rst_overrun", overrun_o, 1'b0);
        check("rst_addr", mem_addr_o, 32'h0);
        check("rst_data", mem_data_o, '0);
        rst = 1'b0;
        step();

        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                tile_sa[r][c] = r * 4 + c + 1;
                tile_px[r][c] = 0;
            end
        end
        feed_tile();
        run_wb(0, 0, 0);
        if (wd.size() == ROWS * CHUNKS) begin
            check("row0_chunk0", wd[0], 48'h0003_0002_0001);
            check("row0_chunk1", wd[1], 48'h0000_0000_0004);
            check("row3_chunk1", wd[7], 48'h0000_0000_0010);
            check("row3_chunk1_addr", wa[7], BASE + 7 * INCR);
        end

        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                tile_sa[r][c] = 100;
                tile_px[r][c] = -30;
            end
        end
        feed_tile();
        run_wb(1, 0, 0);
        if (wd.size() > 0) check("sum_70", wd[0], 48'h0046_0046_0046);
        feed_tile();
        run_wb(0, 0, 0);
        if (wd.size() > 0) check("acc_140", wd[0], 48'h008C_008C_008C);

        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                tile_sa[r][c] = 0;
                tile_px[r][c] = 0;
            end
        end
        tile_sa[0][0] = 30000;
        tile_px[0][0] = 5000;
        tile_sa[0][1] = -30000;
        tile_px[0][1] = -5000;
        feed_tile();
        run_wb(0, 0, 0);
        if (wd.size() > 0) begin
            d = wd[0];
            check("sat_pos", d[15:0], 16'h7FFF);
            check("sat_neg", d[31:16], 16'h8000);
            d = ww[0];
            check("wrap_pos", d[15:0], 16'h88B8);
            check("wrap_neg", d[31:16], 16'h7748);
        end

        rand_tile(-32768, 32767);
        feed_tile();
        run_wb(1, 5, 1);
        run_wb(0, 0, 0);

        rand_tile(-2000, 2000);
        feed_tile();
        run_wb(0, 2, 0);

        sa_valid_i = 4'b0001;
        for (int s = 0; s < 5; s++) begin
            sa_data_i[W-1:0] = W'(s * 10 + 7);
            model_sample(0, 0, s * 10 + 7);
            if (s == 0) begin
                step();
                stall_i = 1'b1;
                repeat (3) step();
                stall_i = 1'b0;
                step();
            end else begin
                step();
                step();
            end
            check("overrun_track", overrun_o, m_ovr);
        end
        sa_valid_i = '0;
        step();
        run_wb(0, 0, 0);
        check("overrun_sticky", overrun_o, 1'b1);

        rand_tile(-1000, 1000);
        feed_tile();
        acc_mode_i = 1'b1;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        cyc = 0;
        while (!mem_wr_en_o && cyc < 10) begin
            step();
            cyc++;
        end
        check("en_before_reset", mem_wr_en_o, 1'b1);
        step();
        rst = 1'b1;
        step();
        check("abort_wr_en", mem_wr_en_o, 1'b0);
        check("abort_busy", busy_o, 1'b0);
        check("abort_done", wr_output_done_o, 1'b0);
        check("abort_overrun", overrun_o, 1'b0);
        rst = 1'b0;
        step();
        check("abort_no_done", wr_output_done_o, 1'b0);
        model_reset();
        run_wb(0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
